// File: rtl/serial_seq_pkg.sv
// Shared state encodings and default field widths for the single-wire
// serial pattern transmitter.
package serial_seq_pkg;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DIV_W  = 8;
   localparam int DEF_GAP_W  = 8;
endpackage

// File: rtl/bit_tick_gen.sv
// Loadable down-counter producing a terminal-count tick every div+1 cycles;
// the reload value is captured on load so later input changes are ignored.
module bit_tick_gen
   import serial_seq_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             run,
   input  logic [DIV_W-1:0] div_in,
   output logic             tick
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == '0);

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load) begin
         div_d = div_in;
         cnt_d = div_in;
      end else if (run) begin
         cnt_d = tick ? div_q : cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_seq_tx.sv
// Serial sequence transmitter: accepts a pattern word over valid/ready and
// shifts it out MSB-first on x1 at a programmable bit period, then idles.
module serial_seq_tx
   import serial_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = $clog2(DATA_W) + 1,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int GAP_W  = DEF_GAP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic [DIV_W-1:0]  div_in,
   input  logic [GAP_W-1:0]  gap_in,
   output logic              x1,
   output logic              bit_strobe,
   output logic              busy,
   output logic              done
);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              x1_q, x1_d;
   logic              strobe_q, strobe_d;
   logic              done_q, done_d;

   logic              accept;
   logic              tick;
   logic [LEN_W-1:0]  len_c;
   logic [LEN_W-1:0]  shamt;
   logic [DATA_W-1:0] aligned;

   // Left-justify the pattern so the first bit to send sits at the MSB.
   assign len_c   = (len_in > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_in;
   assign shamt   = LEN_W'(DATA_W) - len_c;
   assign aligned = data_in << shamt;

   bit_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .run    (state_q == ST_SHIFT),
      .div_in (div_in),
      .tick   (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      x1_d      = x1_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            x1_d = 1'b0;
            if (in_valid) begin
               accept = 1'b1;
               gap_d  = gap_in;
               if (len_c == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = ST_SHIFT;
                  bit_cnt_d = len_c;
                  // x1 takes the first bit now; shreg holds only the rest.
                  x1_d      = aligned[DATA_W-1];
                  shreg_d   = aligned << 1;
                  strobe_d  = 1'b1;
               end
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               if (bit_cnt_q > LEN_W'(1)) begin
                  x1_d      = shreg_q[DATA_W-1];
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q - LEN_W'(1);
                  strobe_d  = 1'b1;
               end else begin
                  x1_d      = 1'b0;
                  bit_cnt_d = '0;
                  if (gap_q != '0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = gap_q - GAP_W'(1);
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         ST_GAP: begin
            x1_d = 1'b0;
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            x1_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         x1_q      <= 1'b0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         x1_q      <= x1_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign x1         = x1_q;
   assign bit_strobe = strobe_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed, table-driven bench for serial_seq_tx; observation vector per
// cycle is {x1, bit_strobe, done, busy, in_ready}.
module tb_serial_seq_tx;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] data_in;
   logic [3:0] len_in;
   logic [7:0] div_in;
   logic [7:0] gap_in;
   logic       x1;
   logic       bit_strobe;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] len;
      logic [7:0] div;
      logic [7:0] gap;
      logic [7:0] bits;   // expected sent bits, first bit at [7]
      int         nbits;  // expected number of bits sent
   } vec_t;

   vec_t vecs[7];

   serial_seq_tx #(
      .DATA_W (8),
      .LEN_W  (4),
      .DIV_W  (8),
      .GAP_W  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .len_in     (len_in),
      .div_in     (div_in),
      .gap_in     (gap_in),
      .x1         (x1),
      .bit_strobe (bit_strobe),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] obs();
      return {x1, bit_strobe, done, busy, in_ready};
   endfunction

   task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b want=%b ({x1,strobe,done,busy,ready})", nm, act, exp);
      end
   endtask

   task automatic run_frame(input int vi);
      vec_t       v;
      int         per;
      int         nfr;
      int         total;
      logic [4:0] exp;
      v     = vecs[vi];
      per   = int'(v.div) + 1;
      nfr   = v.nbits * per;
      total = nfr + int'(v.gap) + 1;
      @(negedge clk);
      data_in  = v.data;
      len_in   = v.len;
      div_in   = v.div;
      gap_in   = v.gap;
      in_valid = 1'b1;
      check($sformatf("v%0d_pre", vi), obs(), 5'b00001);
      for (int c = 1; c <= total; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (c <= nfr)
            exp = {v.bits[7 - (c - 1) / per], ((c - 1) % per) == 0, 1'b0, 1'b1, 1'b0};
         else if (c < total)
            exp = 5'b00010;
         else
            exp = 5'b00101;
         check($sformatf("v%0d_c%0d", vi, c), obs(), exp);
      end
   endtask

   logic [4:0] held_exp[20];
   logic [7:0] pat;

   initial begin
      vecs[0] = '{data: 8'h6D, len: 4'd8,  div: 8'd0, gap: 8'd0, bits: 8'b0110_1101, nbits: 8};
      vecs[1] = '{data: 8'h0D, len: 4'd4,  div: 8'd2, gap: 8'd3, bits: 8'b1101_0000, nbits: 4};
      vecs[2] = '{data: 8'hFF, len: 4'd0,  div: 8'd0, gap: 8'd0, bits: 8'b0000_0000, nbits: 0};
      vecs[3] = '{data: 8'hA5, len: 4'd12, div: 8'd0, gap: 8'd1, bits: 8'b1010_0101, nbits: 8};
      vecs[4] = '{data: 8'hC3, len: 4'd3,  div: 8'd1, gap: 8'd2, bits: 8'b0110_0000, nbits: 3};
      vecs[5] = '{data: 8'h01, len: 4'd1,  div: 8'd4, gap: 8'd0, bits: 8'b1000_0000, nbits: 1};
      vecs[6] = '{data: 8'h35, len: 4'd5,  div: 8'd1, gap: 8'd0, bits: 8'b1010_1000, nbits: 5};

      // Frame 0x0D/len4/div2/gap3 with in_valid held, then a back-to-back
      // frame 0x0F/len2/div0/gap0 accepted in the done cycle.
      held_exp = '{5'b11010, 5'b10010, 5'b10010, 5'b11010, 5'b10010,
                   5'b10010, 5'b01010, 5'b00010, 5'b00010, 5'b11010,
                   5'b10010, 5'b10010, 5'b00010, 5'b00010, 5'b00010,
                   5'b00101, 5'b11010, 5'b11010, 5'b00101, 5'b00001};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = '0;
      len_in   = '0;
      div_in   = '0;
      gap_in   = '0;

      #3;
      check("reset_t0", obs(), 5'b00001);
      repeat (2) @(negedge clk);
      check("reset_held", obs(), 5'b00001);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("idle_%0d", c), obs(), 5'b00001);
      end

      for (int i = 0; i < 7; i++)
         run_frame(i);

      @(negedge clk);
      data_in  = 8'h0D;
      len_in   = 4'd4;
      div_in   = 8'd2;
      gap_in   = 8'd3;
      in_valid = 1'b1;
      check("held_pre", obs(), 5'b00001);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            data_in = 8'h0F;
            len_in  = 4'd2;
            div_in  = 8'd0;
            gap_in  = 8'd0;
         end
         if (c == 17)
            in_valid = 1'b0;
         check($sformatf("held_c%0d", c), obs(), held_exp[c-1]);
      end

      // Reset during bit 3 of 0xB6/len8/div3.
      pat = 8'hB6;
      @(negedge clk);
      data_in  = pat;
      len_in   = 4'd8;
      div_in   = 8'd3;
      gap_in   = 8'd0;
      in_valid = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("mid_c%0d", c), obs(),
               {pat[7 - (c - 1) / 4], ((c - 1) % 4) == 0, 1'b0, 1'b1, 1'b0});
      end
      #1 rst_n = 1'b0;
      #1 check("mid_async_drop", obs(), 5'b00001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check($sformatf("mid_nodone_%0d", c), obs(), 5'b00001);
      end
      run_frame(0);
      run_frame(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
